// File: rtl/i3c_pkg.sv
// Shared types for the DAT/DCT table access arbiter.
// Holds the arbiter select and SW FSM state enums.
package i3c_pkg;

  typedef enum logic [1:0] {
    DxtSelNone,
    DxtSelHw,
    DxtSelSw
  } dxt_arb_sel_e;

  typedef enum logic [1:0] {
    DxtSwIdle,
    DxtSwPend,
    DxtSwWait
  } dxt_sw_state_e;

  localparam int unsigned DxtWordBytes = 4;

endpackage

// File: rtl/dxt_starve_arb.sv
// Two-requester arbiter: HW has priority until MaxHwBurst
// consecutive HW grants have been made while SW waits.
module dxt_starve_arb #(
  parameter int unsigned MaxHwBurst = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       hw_req_i,
  input  logic       sw_req_i,
  output logic [1:0] gnt_o
);

  localparam int unsigned CntW = $clog2(MaxHwBurst + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxHwBurst);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            hw_win;

  assign hw_win = hw_req_i && (cnt_q < CntMax);
  assign gnt_o  = {!hw_win && sw_req_i, hw_win};

  always_comb begin
    cnt_d = cnt_q;
    if (!sw_req_i || gnt_o[1]) begin
      cnt_d = '0;
    end else if (gnt_o[0]) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dxt_arb.sv
// DAT/DCT table SRAM arbiter between HW and 32-bit CSR access.
// DXT_SW_WRITE_EN enables SW writes; otherwise they are acked only.
module dxt_arb
  import i3c_pkg::*;
#(
  parameter int unsigned EntryWidth = 64,
  parameter int unsigned Depth      = 128,
  parameter int unsigned MaxHwBurst = 4,
  localparam int unsigned AddrW    = $clog2(Depth),
  localparam int unsigned Words    = EntryWidth / 32,
  localparam int unsigned WordIdxW =
    (Words > 1) ? $clog2(Words) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      sw_req_i,
  input  logic                      sw_req_is_wr_i,
  input  logic [AddrW+WordIdxW+1:0] sw_addr_i,
  input  logic [31:0]               sw_wr_data_i,
  output logic [31:0]               sw_rd_data_o,
  output logic                      sw_rd_ack_o,
  output logic                      sw_wr_ack_o,
  input  logic                      hw_req_i,
  input  logic                      hw_we_i,
  input  logic [AddrW-1:0]          hw_index_i,
  input  logic [EntryWidth-1:0]     hw_wdata_i,
  output logic                      hw_gnt_o,
  output logic                      hw_rvalid_o,
  output logic [EntryWidth-1:0]     hw_rdata_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [AddrW-1:0]          mem_addr_o,
  output logic [EntryWidth-1:0]     mem_wdata_o,
  output logic [EntryWidth-1:0]     mem_wmask_o,
  input  logic [EntryWidth-1:0]     mem_rdata_i
);

  localparam int unsigned ByteW = $clog2(DxtWordBytes);
  localparam logic [AddrW:0] DepthL = (AddrW + 1)'(Depth);

  dxt_sw_state_e state_q, state_d;
  dxt_arb_sel_e  sel;

  logic                wr_q;
  logic [AddrW-1:0]    idx_q;
  logic [WordIdxW-1:0] word_q;
  logic [31:0]         wdata_q;
  logic                oor_q;
  logic                s1_q, s1_wr_q;
  logic                rd_ack_q, hw_rvalid_q;
  logic [31:0]         rd_data_q, rd_lane;

  logic                idle, in_oor;
  logic [AddrW-1:0]    in_idx, cur_idx;
  logic [WordIdxW-1:0] in_word, cur_word;
  logic                cur_wr, cur_oor;
  logic [31:0]         cur_wdata;
  logic                sw_byp, sw_pend, sw_gnt, iss;
  logic [1:0]          gnt;
  logic                unused_byte;

  assign unused_byte = ^sw_addr_i[ByteW-1:0];

  assign in_idx  = sw_addr_i[ByteW+WordIdxW +: AddrW];
  assign in_word = sw_addr_i[ByteW +: WordIdxW];
  assign in_oor  = {1'b0, in_idx} >= DepthL;

  // Arriving requests are served straight from the ports
  assign idle      = state_q == DxtSwIdle;
  assign cur_wr    = idle ? sw_req_is_wr_i : wr_q;
  assign cur_idx   = idle ? in_idx : idx_q;
  assign cur_word  = idle ? in_word : word_q;
  assign cur_oor   = idle ? in_oor : oor_q;
  assign cur_wdata = idle ? sw_wr_data_i : wdata_q;

`ifdef DXT_SW_WRITE_EN
  assign sw_byp = 1'b0;
`else
  assign sw_byp = idle && sw_req_i && sw_req_is_wr_i;
`endif

  assign sw_pend = (state_q == DxtSwPend) ||
                   (idle && sw_req_i && !sw_byp);

  dxt_starve_arb #(
    .MaxHwBurst(MaxHwBurst)
  ) u_starve (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .hw_req_i(hw_req_i),
    .sw_req_i(sw_pend),
    .gnt_o   (gnt)
  );

  assign hw_gnt_o = gnt[0];
  assign sw_gnt   = gnt[1];
  assign iss      = sw_gnt || sw_byp;

  always_comb begin
    sel = DxtSelNone;
    unique case (1'b1)
      gnt[0]:  sel = DxtSelHw;
      gnt[1]:  sel = DxtSelSw;
      default: sel = DxtSelNone;
    endcase
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wmask_o = '0;
    unique case (sel)
      DxtSelHw: begin
        mem_req_o  = 1'b1;
        mem_we_o   = hw_we_i;
        mem_addr_o = hw_index_i;
        if (hw_we_i) begin
          mem_wdata_o = hw_wdata_i;
          mem_wmask_o = '1;
        end
      end
      DxtSelSw: begin
        if (!cur_oor) begin
          mem_req_o  = 1'b1;
          mem_we_o   = cur_wr;
          mem_addr_o = cur_idx;
          if (cur_wr) begin
            for (int w = 0; w < Words; w++) begin
              if (cur_word == WordIdxW'(w)) begin
                mem_wmask_o[w*32 +: 32] = '1;
                mem_wdata_o[w*32 +: 32] = cur_wdata;
              end
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_lane = '0;
    for (int w = 0; w < Words; w++) begin
      if (word_q == WordIdxW'(w)) begin
        rd_lane = mem_rdata_i[w*32 +: 32];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DxtSwIdle: begin
        if (sw_req_i) begin
          state_d = iss ? DxtSwWait : DxtSwPend;
        end
      end
      DxtSwPend: begin
        if (sw_gnt) state_d = DxtSwWait;
      end
      DxtSwWait: begin
        if (sw_wr_ack_o || sw_rd_ack_o) begin
          state_d = DxtSwIdle;
        end
      end
      default: state_d = DxtSwIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= DxtSwIdle;
      wr_q        <= 1'b0;
      idx_q       <= '0;
      word_q      <= '0;
      wdata_q     <= '0;
      oor_q       <= 1'b0;
      s1_q        <= 1'b0;
      s1_wr_q     <= 1'b0;
      rd_ack_q    <= 1'b0;
      rd_data_q   <= '0;
      hw_rvalid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (idle && sw_req_i) begin
        wr_q    <= sw_req_is_wr_i;
        idx_q   <= in_idx;
        word_q  <= in_word;
        wdata_q <= sw_wr_data_i;
        oor_q   <= in_oor;
      end
      s1_q     <= iss;
      s1_wr_q  <= cur_wr;
      rd_ack_q <= s1_q && !s1_wr_q;
      if (s1_q && !s1_wr_q) begin
        rd_data_q <= oor_q ? '0 : rd_lane;
      end
      hw_rvalid_q <= hw_gnt_o && !hw_we_i;
    end
  end

`ifdef DXT_SW_WRITE_EN
  assign sw_wr_ack_o = s1_q && s1_wr_q;
`else
  // Bypassed writes need one extra stage to ack two cycles out
  logic wr_ack_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ack_q <= 1'b0;
    end else begin
      wr_ack_q <= s1_q && s1_wr_q;
    end
  end

  assign sw_wr_ack_o = wr_ack_q;
`endif

  assign sw_rd_ack_o  = rd_ack_q;
  assign sw_rd_data_o = rd_data_q;
  assign hw_rvalid_o  = hw_rvalid_q;
  assign hw_rdata_o   = hw_rvalid_q ? mem_rdata_i : '0;

  sw_req_protocol: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    sw_req_i |-> idle
  );

endmodule

// File: tb/tb_dxt_arb.sv
// Directed bench for dxt_arb: 128-bit entries, Depth 100,
// MaxHwBurst 4, with a behavioural single-port SRAM.
module tb_dxt_arb;

  localparam int EW = 128;
  localparam int DP = 100;
  localparam int MB = 4;
  localparam int AW = 7;
  localparam int SAW = 11;

`ifdef DXT_SW_WRITE_EN
  localparam bit SwWrEn = 1'b1;
`else
  localparam bit SwWrEn = 1'b0;
`endif

  localparam logic [EW-1:0] Lane2Mask =
    128'h00000000_FFFFFFFF_00000000_00000000;
  localparam logic [EW-1:0] Lane2Data =
    128'h00000000_A5A50001_00000000_00000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic           sw_req, sw_wr;
  logic [SAW-1:0] sw_addr;
  logic [31:0]    sw_wdata, sw_rdata;
  logic           sw_rd_ack, sw_wr_ack;
  logic           hw_req, hw_we, hw_gnt, hw_rvalid;
  logic [AW-1:0]  hw_idx;
  logic [EW-1:0]  hw_wdata, hw_rdata;
  logic           mem_req, mem_we;
  logic [AW-1:0]  mem_addr;
  logic [EW-1:0]  mem_wdata, mem_wmask;
  logic [EW-1:0]  rdata_q = '0;
  logic [EW-1:0]  mem [DP] = '{default: '0};

  int checks = 0;
  int errors = 0;

  dxt_arb #(
    .EntryWidth(EW),
    .Depth     (DP),
    .MaxHwBurst(MB)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .sw_req_i      (sw_req),
    .sw_req_is_wr_i(sw_wr),
    .sw_addr_i     (sw_addr),
    .sw_wr_data_i  (sw_wdata),
    .sw_rd_data_o  (sw_rdata),
    .sw_rd_ack_o   (sw_rd_ack),
    .sw_wr_ack_o   (sw_wr_ack),
    .hw_req_i      (hw_req),
    .hw_we_i       (hw_we),
    .hw_index_i    (hw_idx),
    .hw_wdata_i    (hw_wdata),
    .hw_gnt_o      (hw_gnt),
    .hw_rvalid_o   (hw_rvalid),
    .hw_rdata_o    (hw_rdata),
    .mem_req_o     (mem_req),
    .mem_we_o      (mem_we),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_wmask_o   (mem_wmask),
    .mem_rdata_i   (rdata_q)
  );

  always @(posedge clk) begin
    if (mem_req && int'(mem_addr) < DP) begin
      if (mem_we) begin
        mem[mem_addr] <= (mem[mem_addr] & ~mem_wmask) |
                         (mem_wdata & mem_wmask);
      end
      rdata_q <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag,
                     input logic [EW-1:0] obs,
                     input logic [EW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    sw_req = 1'b0; sw_wr = 1'b0; sw_addr = '0; sw_wdata = '0;
    hw_req = 1'b0; hw_we = 1'b0; hw_idx = '0; hw_wdata = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_hw_gnt", hw_gnt, 0);
    chk("rst_rd_ack", sw_rd_ack, 0);
    chk("rst_wr_ack", sw_wr_ack, 0);
    chk("rst_rvalid", hw_rvalid, 0);
    chk("rst_rd_data", sw_rdata, 0);
    rst_n = 1'b1;

    // SW write 0xA5A50001 to byte 0x18: index 1, lane 2
    tick;
    sw_req = 1'b1; sw_wr = 1'b1;
    sw_addr = 11'h018; sw_wdata = 32'hA5A5_0001;
    settle;
    chk("swwr_req", mem_req, SwWrEn);
    chk("swwr_we", mem_we, SwWrEn);
    chk("swwr_addr", mem_addr, SwWrEn ? 1 : 0);
    chk("swwr_mask", mem_wmask, SwWrEn ? Lane2Mask : '0);
    chk("swwr_data", mem_wdata, SwWrEn ? Lane2Data : '0);
    tick;
    sw_req = 1'b0; sw_wr = 1'b0;
    settle;
    chk("swwr_ack_c1", sw_wr_ack, SwWrEn);
    tick;
    settle;
    chk("swwr_ack_c2", sw_wr_ack, !SwWrEn);
    chk("swwr_mem", mem[1], SwWrEn ? Lane2Data : '0);

    // SW read back from 0x18
    tick;
    sw_req = 1'b1; sw_addr = 11'h018;
    settle;
    chk("swrd_req", mem_req, 1);
    chk("swrd_we", mem_we, 0);
    chk("swrd_addr", mem_addr, 1);
    chk("swrd_mask", mem_wmask, '0);
    tick;
    sw_req = 1'b0;
    settle;
    chk("swrd_ack_g1", sw_rd_ack, 0);
    tick;
    settle;
    chk("swrd_ack_g2", sw_rd_ack, 1);
    chk("swrd_data", sw_rdata, SwWrEn ? 32'hA5A5_0001 : 32'h0);
    tick;
    settle;
    chk("swrd_ack_g3", sw_rd_ack, 0);

    // HW write index 5 all ones, then HW read
    tick;
    hw_req = 1'b1; hw_we = 1'b1; hw_idx = 7'd5; hw_wdata = '1;
    settle;
    chk("hwwr_gnt", hw_gnt, 1);
    chk("hwwr_we", mem_we, 1);
    chk("hwwr_addr", mem_addr, 5);
    chk("hwwr_mask", mem_wmask, '1);
    chk("hwwr_data", mem_wdata, '1);
    tick;
    hw_we = 1'b0; hw_wdata = '0;
    settle;
    chk("hwrd_gnt", hw_gnt, 1);
    chk("hwrd_rv_wr", hw_rvalid, 0);
    tick;
    hw_req = 1'b0;
    settle;
    chk("hwrd_rvalid", hw_rvalid, 1);
    chk("hwrd_rdata", hw_rdata, '1);
    chk("hwrd_idle_req", mem_req, 0);
    tick;
    settle;
    chk("hwrd_rv_end", hw_rvalid, 0);

    // Continuous HW reads of index 3 vs SW read of index 5
    tick;
    hw_req = 1'b1; hw_idx = 7'd3;
    sw_req = 1'b1; sw_addr = 11'h050;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) begin
        tick;
        sw_req = 1'b0;
      end
      settle;
      chk($sformatf("stv_gnt_c%0d", c), hw_gnt, c != 4);
      chk($sformatf("stv_ack_c%0d", c), sw_rd_ack, c == 6);
      chk($sformatf("stv_rv_c%0d", c), hw_rvalid,
          c != 0 && c != 5);
      if (c == 0) chk("stv_addr_c0", mem_addr, 3);
      if (c == 4) chk("stv_addr_c4", mem_addr, 5);
      if (c == 6) chk("stv_data", sw_rdata, 32'hFFFF_FFFF);
    end
    hw_req = 1'b0;

    // Reset at G+1 of a SW read
    tick;
    sw_req = 1'b1; sw_addr = 11'h050;
    settle;
    chk("rstm_g0_req", mem_req, 1);
    tick;
    sw_req = 1'b0;
    rst_n = 1'b0;
    settle;
    chk("rstm_rd_data", sw_rdata, 0);
    chk("rstm_rd_ack", sw_rd_ack, 0);
    chk("rstm_mem_req", mem_req, 0);
    chk("rstm_rvalid", hw_rvalid, 0);
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle;
      chk($sformatf("rstm_noack_%0d", i), sw_rd_ack, 0);
      tick;
    end
    sw_req = 1'b1; sw_addr = 11'h050;
    settle;
    chk("rstm_idle_gnt", mem_req, 1);
    tick;
    sw_req = 1'b0;
    tick;
    settle;
    chk("rstm_re_ack", sw_rd_ack, 1);
    chk("rstm_re_data", sw_rdata, 32'hFFFF_FFFF);

    // Out-of-range read: index 110 of 100
    tick;
    sw_req = 1'b1; sw_addr = 11'h6E0;
    settle;
    chk("oor_req", mem_req, 0);
    tick;
    sw_req = 1'b0;
    settle;
    chk("oor_ack_c1", sw_rd_ack, 0);
    tick;
    settle;
    chk("oor_ack_c2", sw_rd_ack, 1);
    chk("oor_data", sw_rdata, 0);

    tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
